syn_accumulator: RTL

Synaptic input integrator between the per-neuron weight RAM and the Izhikevich neuron update core. On `start` it latches the presynaptic spike vector and walks every weight-RAM address through the RAM's asynchronous read port. It sums the signed weights of the presynaptic neurons that spiked and registers the total as the synaptic current `current`. The neuron core consumes `current` on the `done` pulse.

---
 rtl/syn_accumulator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/syn_accumulator.sv
// Synaptic input integrator: scans all weight-RAM addresses after a start request
// and sums, with per-step saturation, the signed weights of neurons that spiked.
module syn_accumulator #(
  parameter int NEURON_ADR = 5,
  parameter int WEIGHTS    = 10,
  parameter int ACC_W      = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [2**(NEURON_ADR+1)-1:0]    i_spikes,
  output logic [NEURON_ADR:0]             o_dpra,
  input  logic [WEIGHTS:0]                i_dpo,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [ACC_W-1:0]                o_current,
  output logic                            o_sat
);

  localparam int DEPTH = 2**(NEURON_ADR+1);
  localparam logic [NEURON_ADR:0] LAST_ADR = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [NEURON_ADR:0] r_addr;
  logic [DEPTH-1:0]    r_spk;
  logic [ACC_W-1:0]    r_acc;
  logic                r_satQ;
  logic [ACC_W-1:0]    r_current;
  logic                r_sat;
  logic                r_busy;
  logic                r_done;

  logic [ACC_W-1:0]    w_dpoExt;
  logic [ACC_W:0]      w_sum;
  logic                w_addSel;
  logic                w_clampHi;
  logic                w_clampLo;
  logic                w_stepSat;
  logic [ACC_W-1:0]    w_accNext;
  logic                w_lastAddr;

  // One extra guard bit makes overflow visible as a disagreement of the top two sum bits.
  always_comb begin
    w_dpoExt  = {{(ACC_W-WEIGHTS-1){i_dpo[WEIGHTS]}}, i_dpo};
    w_sum     = {r_acc[ACC_W-1], r_acc} + {w_dpoExt[ACC_W-1], w_dpoExt};
    w_addSel  = r_spk[r_addr];
    w_clampHi = (w_sum[ACC_W] == 1'b0) && (w_sum[ACC_W-1] == 1'b1);
    w_clampLo = (w_sum[ACC_W] == 1'b1) && (w_sum[ACC_W-1] == 1'b0);
    w_stepSat = w_addSel && (w_clampHi || w_clampLo);
    w_accNext = r_acc;
    if (w_addSel) begin
      if (w_clampHi)
        w_accNext = ACC_MAX;
      else if (w_clampLo)
        w_accNext = ACC_MIN;
      else
        w_accNext = w_sum[ACC_W-1:0];
    end
    w_lastAddr = (r_addr == LAST_ADR);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = SCAN;
      SCAN:    if (w_lastAddr) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_spk     <= '0;
      r_acc     <= '0;
      r_satQ    <= 1'b0;
      r_current <= '0;
      r_sat     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_spk  <= i_spikes;
            r_acc  <= '0;
            r_satQ <= 1'b0;
            r_addr <= '0;
            r_busy <= 1'b1;
          end
        end
        SCAN: begin
          r_acc  <= w_accNext;
          r_satQ <= r_satQ | w_stepSat;
          r_addr <= r_addr + 1'b1;
          // The last step publishes its own result, including a clamp on that step.
          if (w_lastAddr) begin
            r_current <= w_accNext;
            r_sat     <= r_satQ | w_stepSat;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_addr    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dpra    = r_addr;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_current = r_current;
  assign o_sat     = r_sat;

endmodule
